// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction cache and its interfaces.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} icache_state_t;

  // Address split for the default 16-frame direct-mapped icache
  localparam int ITAG_W  = 26;
  localparam int IIDX_W  = 4;
  localparam int IBYTE_W = 2;

  typedef struct packed {
    logic [ITAG_W-1:0]  tag;
    logic [IIDX_W-1:0]  idx;
    logic [IBYTE_W-1:0] bytoff;
  } icachef_t;
endpackage

// File: rtl/icache_if.sv
// Datapath-to-cache and cache-to-controller bundles for the instruction side.
interface datapath_cache_if;
  import cpu_types_pkg::*;
  logic  imemREN, ihit;
  word_t imemaddr, imemload;

  modport dp     (output imemREN, imemaddr, input  ihit, imemload);
  modport icache (input  imemREN, imemaddr, output ihit, imemload);
endinterface

interface cache_control_if;
  import cpu_types_pkg::*;
  logic  iREN, iwait;
  word_t iaddr, iload;

  modport icache (output iREN, iaddr, input  iwait, iload);
  modport cc     (input  iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only icache: combinational hit path, single-word fill on miss.
module icache
  import cpu_types_pkg::*;
#(
  parameter  int NUM_FRAMES = 16,
  localparam int IDX_W      = $clog2(NUM_FRAMES),
  localparam int TAG_W      = 30 - IDX_W
) (
  input logic              CLK,
  input logic              nRST,
  datapath_cache_if.icache dcif,
  cache_control_if.icache  ccif
);
  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_FETCH = FETCH;

  logic [0:0]            state, state_n;
  word_t                 fill_addr, fill_addr_n;
  logic [NUM_FRAMES-1:0] valid;
  logic [TAG_W-1:0]      tags [NUM_FRAMES];
  word_t                 data [NUM_FRAMES];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit, fill_we;
  logic             unused_bytoff;

  assign req_idx  = dcif.imemaddr[IDX_W+1:2];
  assign req_tag  = dcif.imemaddr[31:IDX_W+2];
  assign fill_idx = fill_addr[IDX_W+1:2];
  assign fill_tag = fill_addr[31:IDX_W+2];
  assign unused_bytoff = ^dcif.imemaddr[1:0];

  // Lookup is only honoured in IDLE; no hit-under-miss
  assign hit = (state == ST_IDLE) && dcif.imemREN && valid[req_idx]
               && (tags[req_idx] == req_tag);

  assign dcif.ihit     = hit;
  assign dcif.imemload = hit ? data[req_idx] : 32'h0;
  assign ccif.iREN     = (state == ST_FETCH);
  assign ccif.iaddr    = fill_addr;

  always_comb begin
    state_n     = state;
    fill_addr_n = fill_addr;
    fill_we     = 1'b0;
    case (state)
      ST_IDLE: if (dcif.imemREN && !hit) begin
        fill_addr_n = {dcif.imemaddr[31:2], 2'b00};
        state_n     = ST_FETCH;
      end
      // Fill runs to completion regardless of what the datapath does meanwhile
      ST_FETCH: if (!ccif.iwait) begin
        fill_we = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      fill_addr <= '0;
      valid     <= '0;
      for (int i = 0; i < NUM_FRAMES; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      state     <= state_n;
      fill_addr <= fill_addr_n;
      if (fill_we) begin
        valid[fill_idx] <= 1'b1;
        tags[fill_idx]  <= fill_tag;
        data[fill_idx]  <= ccif.iload;
      end
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fills, hits, conflicts, mid-fill changes, reset.
module tb_icache;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_chk = 0, n_pass = 0;

  datapath_cache_if dcif ();
  cache_control_if  ccif ();

  icache #(.NUM_FRAMES(16)) dut (.CLK(CLK), .nRST(nRST), .dcif(dcif), .ccif(ccif));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Miss on a, fill d after w wait cycles, then confirm the hit the cycle after
  task automatic miss_fill(input word_t a, input word_t d, input int w);
    dcif.imemREN = 1'b1; dcif.imemaddr = a; ccif.iwait = 1'b1;
    #1;
    chk("miss_ihit", dcif.ihit, 0);
    chk("idle_iren", ccif.iREN, 0);
    step();
    chk("fetch_iren",  ccif.iREN, 1);
    chk("fetch_iaddr", ccif.iaddr, {a[31:2], 2'b00});
    chk("fetch_ihit",  dcif.ihit, 0);
    ccif.iload = d;
    repeat (w) step();
    chk("wait_iren", ccif.iREN, 1);
    ccif.iwait = 1'b0;
    step();
    ccif.iwait = 1'b1;
    chk("post_iren", ccif.iREN, 0);
    chk("post_ihit", dcif.ihit, 1);
    chk("post_load", dcif.imemload, d);
  endtask

  initial begin
    nRST = 1'b0;
    dcif.imemREN = 1'b0; dcif.imemaddr = '0;
    ccif.iwait = 1'b1; ccif.iload = '0;
    #3;
    chk("rst_iren",  ccif.iREN, 0);
    chk("rst_iaddr", ccif.iaddr, 0);
    chk("rst_ihit",  dcif.ihit, 0);
    chk("rst_load",  dcif.imemload, 0);
    #9 nRST = 1'b1;
    step();

    // Cold miss on 0x0, 3 wait cycles
    miss_fill(32'h0, 32'h2001000A, 3);

    // Re-read and byte-offset alias hit with no iREN
    dcif.imemaddr = 32'h0; #1;
    chk("reread_hit", dcif.ihit, 1);
    step();
    chk("reread_iren", ccif.iREN, 0);
    dcif.imemaddr = 32'h3; #1;
    chk("off3_hit",  dcif.ihit, 1);
    chk("off3_load", dcif.imemload, 32'h2001000A);
    dcif.imemREN = 1'b0; #1;
    chk("noren_ihit", dcif.ihit, 0);
    chk("noren_load", dcif.imemload, 0);
    step();
    chk("noren_iren", ccif.iREN, 0);

    // Conflict on index 1: 0x04 then 0x44 then 0x04 again
    miss_fill(32'h04, 32'hAAAA0004, 1);
    miss_fill(32'h44, 32'hBBBB0044, 0);
    miss_fill(32'h04, 32'hAAAA0004, 2);

    // Address change mid-fill
    dcif.imemREN = 1'b1; dcif.imemaddr = 32'h10; ccif.iwait = 1'b1; #1;
    chk("chg_miss", dcif.ihit, 0);
    step();
    dcif.imemaddr = 32'h20; #1;
    chk("chg_iaddr", ccif.iaddr, 32'h10);
    chk("chg_iren",  ccif.iREN, 1);
    chk("chg_ihit",  dcif.ihit, 0);
    ccif.iload = 32'hCCCC0010; ccif.iwait = 1'b0;
    step();
    ccif.iwait = 1'b1;
    chk("chg_new_miss", dcif.ihit, 0);
    chk("chg_idle_iren", ccif.iREN, 0);
    step();
    chk("chg2_iren",  ccif.iREN, 1);
    chk("chg2_iaddr", ccif.iaddr, 32'h20);
    ccif.iload = 32'hDDDD0020; ccif.iwait = 1'b0;
    step();
    ccif.iwait = 1'b1;
    chk("chg2_hit",  dcif.ihit, 1);
    chk("chg2_load", dcif.imemload, 32'hDDDD0020);
    dcif.imemaddr = 32'h10; #1;
    chk("chg_old_hit",  dcif.ihit, 1);
    chk("chg_old_load", dcif.imemload, 32'hCCCC0010);
    step();

    // imemREN dropped mid-FETCH
    dcif.imemaddr = 32'h30; #1;
    chk("drop_miss", dcif.ihit, 0);
    step();
    dcif.imemREN = 1'b0; ccif.iload = 32'hEEEE0030;
    step();
    chk("drop_iren1", ccif.iREN, 1);
    step();
    chk("drop_iren2", ccif.iREN, 1);
    chk("drop_iaddr", ccif.iaddr, 32'h30);
    ccif.iwait = 1'b0;
    step();
    ccif.iwait = 1'b1;
    chk("drop_done_iren", ccif.iREN, 0);
    chk("drop_done_ihit", dcif.ihit, 0);
    dcif.imemREN = 1'b1; #1;
    chk("drop_hit",  dcif.ihit, 1);
    chk("drop_load", dcif.imemload, 32'hEEEE0030);
    step();

    // Reset asserted mid-FETCH
    dcif.imemaddr = 32'h50; #1;
    chk("rstf_miss", dcif.ihit, 0);
    step();
    chk("rstf_iren_pre", ccif.iREN, 1);
    nRST = 1'b0; #1;
    chk("rstf_iren",  ccif.iREN, 0);
    chk("rstf_iaddr", ccif.iaddr, 0);
    #2 nRST = 1'b1;
    dcif.imemaddr = 32'h0; #1;
    chk("rstf_0_miss", dcif.ihit, 0);
    dcif.imemaddr = 32'h30; #1;
    chk("rstf_30_miss", dcif.ihit, 0);
    dcif.imemREN = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
